// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI slave front end: MOSI frame deserialiser and MISO read-data serialiser
module spi_slave_if #(
    parameter int FRAME_W = 10,
    parameter int TX_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [TX_W-1:0]    tx_data,
    input  logic               tx_valid
);

    // The counter has to reach FRAME_W-1 while receiving and TX_W-1 while sending.
    localparam int CNT_W = $clog2((FRAME_W > TX_W ? FRAME_W : TX_W) + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        WAIT_TX,
        SEND,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-2:0] shift_in;
    logic [TX_W-2:0]    tx_shift;
    logic               rd_addr_seen;
    logic               frame_last;
    logic               send_last;

    assign frame_last = (bit_cnt == CNT_W'(FRAME_W - 1));
    assign send_last  = (bit_cnt == CNT_W'(TX_W - 1));

    // State register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; SS_n high aborts from any state.
    always_comb begin
        next_state = state;
        if (SS_n) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:      next_state = CHK_CMD;
                CHK_CMD:   next_state = MOSI ? (rd_addr_seen ? READ_DATA : READ_ADD) : WRITE;
                WRITE:     if (frame_last) next_state = DONE;
                READ_ADD:  if (frame_last) next_state = DONE;
                READ_DATA: if (frame_last) next_state = WAIT_TX;
                WAIT_TX:   if (tx_valid) next_state = SEND;
                SEND:      if (send_last) next_state = DONE;
                DONE:      next_state = DONE;
                default:   next_state = IDLE;
            endcase
        end
    end

    // Datapath: frame shift-in, rx strobe, read-address tracking and MISO shift-out.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt      <= '0;
            shift_in     <= '0;
            tx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            MISO         <= 1'b0;
            rd_addr_seen <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            MISO     <= 1'b0;
            if (SS_n) begin
                bit_cnt <= '0;
            end else begin
                case (state)
                    WRITE, READ_ADD, READ_DATA: begin
                        if (frame_last) begin
                            rx_data  <= {shift_in, MOSI};
                            rx_valid <= 1'b1;
                            bit_cnt  <= '0;
                            if (state == READ_ADD) begin
                                rd_addr_seen <= 1'b1;
                            end
                            if (state == READ_DATA) begin
                                rd_addr_seen <= 1'b0;
                            end
                        end else begin
                            shift_in <= {shift_in[FRAME_W-3:0], MOSI};
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                        end
                    end
                    WAIT_TX: begin
                        // The latching edge already presents the MSB on MISO.
                        if (tx_valid) begin
                            tx_shift <= tx_data[TX_W-2:0];
                            MISO     <= tx_data[TX_W-1];
                            bit_cnt  <= '0;
                        end
                    end
                    SEND: begin
                        if (send_last) begin
                            bit_cnt <= '0;
                        end else begin
                            MISO     <= tx_shift[TX_W-2];
                            tx_shift <= {tx_shift[TX_W-3:0], 1'b0};
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        bit_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
